// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool_pkg
// Purpose  : Shared constants for the 2x2 max-pooling engine.
// Revision : 1.0
// ============================================================================
package pool_pkg;

    localparam logic [17:0] c_ofmap_base = 18'd131072;
    localparam logic [17:0] c_pool_base  = 18'd196608;

    localparam int c_chnl_w  = 4;
    localparam int c_coord_w = 5;
    localparam int c_state_w = 5;

    localparam logic [c_state_w-1:0] c_st_idle  = 5'b00001;
    localparam logic [c_state_w-1:0] c_st_rd    = 5'b00010;
    localparam logic [c_state_w-1:0] c_st_drain = 5'b00100;
    localparam logic [c_state_w-1:0] c_st_wr    = 5'b01000;
    localparam logic [c_state_w-1:0] c_st_done  = 5'b10000;

    localparam logic [1:0] c_win_00 = 2'd0;
    localparam logic [1:0] c_win_01 = 2'd1;
    localparam logic [1:0] c_win_11 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pool_max_unit.sv
`default_nettype none
// ============================================================================
// Module   : pool_max_unit
// Purpose  : Signed running-maximum register with clear/load/update controls.
// Revision : 1.0
// ============================================================================
module pool_max_unit
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  update,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] max_val
);

    logic [DATA_WIDTH-1:0] r_max;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_max <= '0;
        end else if (clear) begin
            r_max <= '0;
        end else if (load) begin
            r_max <= din;
        end else if (update && ($signed(din) > $signed(r_max))) begin
            r_max <= din;
        end
    end

    assign max_val = r_max;

endmodule
`default_nettype wire

// File: rtl/pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pool_ctrl
// Purpose  : 2x2 stride-2 max-pooling engine over a DRAM-resident feature map.
// Revision : 1.0
// ============================================================================
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE = c_ofmap_base,
    parameter logic [ADDR_WIDTH-1:0] POOL_BASE  = c_pool_base
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic [4:0]            num_chnl,
    input  logic [5:0]            ofmap_height,
    input  logic [5:0]            ofmap_width,
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  dram_en_wr,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  busy
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;

    logic [4:0]           r_nchnl;
    logic [c_coord_w-1:0] r_ph;
    logic [c_coord_w-1:0] r_pw;
    logic [c_chnl_w-1:0]  r_c;
    logic [c_coord_w-1:0] r_py;
    logic [c_coord_w-1:0] r_px;
    logic [1:0]           r_cnt_win;

    logic                  w_start;
    logic                  w_zero;
    logic                  w_last_px;
    logic                  w_last_py;
    logic                  w_last_win;
    logic [c_coord_w-1:0]  w_y;
    logic [c_coord_w-1:0]  w_x;
    logic                  w_max_load;
    logic                  w_max_update;
    logic [DATA_WIDTH-1:0] w_max;

    assign w_start    = (r_state == c_st_idle) && enable;
    assign w_zero     = (num_chnl == 5'd0) || (ofmap_height < 6'd2) || (ofmap_width < 6'd2);
    assign w_last_px  = (r_px == r_pw - 5'd1);
    assign w_last_py  = (r_py == r_ph - 5'd1);
    assign w_last_win = ({1'b0, r_c} == r_nchnl - 5'd1) && w_last_py && w_last_px;

    // Window sample (y,x) = (2py + win[1], 2px + win[0])
    assign w_y = r_py + r_py + {4'd0, r_cnt_win[1]};
    assign w_x = r_px + r_px + {4'd0, r_cnt_win[0]};

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dram_en_rd  = 1'b0;
        addr_in     = '0;
        dram_en_wr  = 1'b0;
        addr_out    = '0;
        data_out    = '0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            c_st_idle: begin
                busy = 1'b0;
                if (enable) begin
                    w_state_nxt = w_zero ? c_st_done : c_st_rd;
                end
            end
            c_st_rd: begin
                dram_en_rd = 1'b1;
                addr_in    = OFMAP_BASE + ADDR_WIDTH'({4'd0, r_c, w_y, w_x});
                if (r_cnt_win == c_win_11) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                w_state_nxt = c_st_wr;
            end
            c_st_wr: begin
                dram_en_wr  = 1'b1;
                addr_out    = POOL_BASE + ADDR_WIDTH'({4'd0, r_c, r_py, r_px});
                data_out    = w_max;
                w_state_nxt = w_last_win ? c_st_done : c_st_rd;
            end
            c_st_done: begin
                done        = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_nchnl   <= '0;
            r_ph      <= '0;
            r_pw      <= '0;
            r_c       <= '0;
            r_py      <= '0;
            r_px      <= '0;
            r_cnt_win <= c_win_00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (enable) begin
                        r_nchnl   <= num_chnl;
                        r_ph      <= 5'(ofmap_height >> 1);
                        r_pw      <= 5'(ofmap_width >> 1);
                        r_c       <= '0;
                        r_py      <= '0;
                        r_px      <= '0;
                        r_cnt_win <= c_win_00;
                    end
                end
                c_st_rd: begin
                    r_cnt_win <= r_cnt_win + 2'd1;
                end
                c_st_wr: begin
                    if (!w_last_win) begin
                        if (w_last_px) begin
                            r_px <= '0;
                            if (w_last_py) begin
                                r_py <= '0;
                                r_c  <= r_c + 4'd1;
                            end else begin
                                r_py <= r_py + 5'd1;
                            end
                        end else begin
                            r_px <= r_px + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read data lags the address by one cycle: sample 0 arrives while cnt_win==1,
    // and the last sample lands during DRAIN.
    assign w_max_load   = (r_state == c_st_rd) && (r_cnt_win == c_win_01);
    assign w_max_update = ((r_state == c_st_rd) && r_cnt_win[1]) || (r_state == c_st_drain);

    pool_max_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_max (
        .clk     (clk),
        .srstn   (srstn),
        .clear   (w_start),
        .load    (w_max_load),
        .update  (w_max_update),
        .din     (data_in),
        .max_val (w_max)
    );

endmodule
`default_nettype wire

// File: tb/tb_pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_ctrl
// Purpose  : Directed self-checking bench for pool_ctrl with a behavioural DRAM.
// Revision : 1.0
// ============================================================================
module tb_pool_ctrl;

    logic        clk = 1'b0;
    logic        srstn;
    logic        enable;
    logic [4:0]  num_chnl;
    logic [5:0]  ofmap_height;
    logic [5:0]  ofmap_width;
    logic        dram_en_rd;
    logic [17:0] addr_in;
    logic [31:0] data_in = 32'd0;
    logic        dram_en_wr;
    logic [17:0] addr_out;
    logic [31:0] data_out;
    logic        done;
    logic        busy;

    pool_ctrl dut (
        .clk          (clk),
        .srstn        (srstn),
        .enable       (enable),
        .num_chnl     (num_chnl),
        .ofmap_height (ofmap_height),
        .ofmap_width  (ofmap_width),
        .dram_en_rd   (dram_en_rd),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .dram_en_wr   (dram_en_wr),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [17:0]];

    always @(posedge clk) begin
        data_in <= (dram_en_rd && mem.exists(addr_in)) ? mem[addr_in] : 32'd0;
    end

    typedef struct {
        logic [17:0] addr;
        logic [31:0] data;
        int          t;
    } acc_t;

    acc_t rd_log[$];
    acc_t wr_log[$];
    int   cyc = 0;
    int   t0 = 0;
    int   done_t = -1;
    int   busy_cnt = 0;
    bit   done_seen = 1'b0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Times are logged relative to the accepting edge: first RD cycle is T1
    always @(negedge clk) begin
        if (dram_en_rd) rd_log.push_back('{addr: addr_in, data: 32'd0, t: cyc - t0 + 1});
        if (dram_en_wr) wr_log.push_back('{addr: addr_out, data: data_out, t: cyc - t0 + 1});
        if (done && !done_seen) begin
            done_seen = 1'b1;
            done_t    = cyc - t0 + 1;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        done_seen = 1'b0;
        done_t    = -1;
        busy_cnt  = 0;
    endtask

    task automatic start(input int nch, input int h, input int w);
        @(negedge clk);
        clear_logs();
        num_chnl     = 5'(nch);
        ofmap_height = 6'(h);
        ofmap_width  = 6'(w);
        t0           = cyc + 1;
        enable       = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done_seen && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic load_small(input int a, input int b, input int c, input int d);
        mem[18'd131072] = 32'(a);
        mem[18'd131073] = 32'(b);
        mem[18'd131104] = 32'(c);
        mem[18'd131105] = 32'(d);
    endtask

    // Pattern c*100 + 10x - 3y: each window's max sits at (2py, 2px+1)
    task automatic load_pattern(input int nch, input int dim, input bit poison_edge);
        mem.delete();
        for (int c = 0; c < nch; c++)
            for (int y = 0; y < dim; y++)
                for (int x = 0; x < dim; x++)
                    mem[18'(131072 + c * 1024 + y * 32 + x)] =
                        (poison_edge && (y == 4 || x == 4)) ? 32'd1000 : 32'(c * 100 + x * 10 - y * 3);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_rd"},   32'(dram_en_rd), 32'd0);
        check({pfx, "_addr_in"}, 32'(addr_in), 32'd0);
        check({pfx, "_wr"},   32'(dram_en_wr), 32'd0);
        check({pfx, "_addr_out"}, 32'(addr_out), 32'd0);
        check({pfx, "_data_out"}, data_out, 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_a[4];
        int          c, py, px, nbad;
        logic [17:0] off;

        srstn = 1'b0;
        enable = 1'b0;
        num_chnl = 5'd0;
        ofmap_height = 6'd0;
        ofmap_width = 6'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("in_reset");
        srstn = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("post_reset");

        // Single 2x2 window, mixed signs
        mem.delete();
        load_small(5, -3, 7, 1);
        start(1, 2, 2);
        wait_done(50);
        exp_a = '{131072, 131073, 131104, 131105};
        check("t1_nrd", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_log.size()) begin
                check("t1_rd_addr", 32'(rd_log[i].addr), exp_a[i]);
                check("t1_rd_t", rd_log[i].t, i + 1);
            end
        end
        check("t1_nwr", wr_log.size(), 1);
        if (wr_log.size() > 0) begin
            check("t1_wr_addr", 32'(wr_log[0].addr), 196608);
            check("t1_wr_data", wr_log[0].data, 7);
            check("t1_wr_t", wr_log[0].t, 6);
        end
        check("t1_done_t", done_t, 7);
        check("t1_busy_cnt", busy_cnt, 7);

        // All-negative window: first sample must load, compare must be signed
        load_small(-8, -2, -5, -9);
        start(1, 2, 2);
        wait_done(50);
        check("t2_nwr", wr_log.size(), 1);
        if (wr_log.size() > 0) check("t2_wr_data", wr_log[0].data, 32'hFFFF_FFFE);

        // 2 channels, 4x4 map
        load_pattern(2, 4, 1'b0);
        start(2, 4, 4);
        wait_done(100);
        check("t3_nwr", wr_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            c  = i / 4;
            py = (i / 2) % 2;
            px = i % 2;
            if (i < wr_log.size()) begin
                check("t3_wr_addr", 32'(wr_log[i].addr), 196608 + c * 1024 + py * 32 + px);
                check("t3_wr_data", wr_log[i].data, 32'(c * 100 + (2 * px + 1) * 10 - 6 * py));
                check("t3_wr_t", wr_log[i].t, 6 * (i + 1));
            end
        end
        check("t3_nrd", rd_log.size(), 32);
        exp_a = '{132162, 132163, 132194, 132195};
        for (int i = 0; i < 4; i++) begin
            if (28 + i < rd_log.size()) check("t3_rd_last_win", 32'(rd_log[28 + i].addr), exp_a[i]);
        end
        check("t3_done_t", done_t, 49);

        // 5x5 map: odd row/column must never be touched
        load_pattern(1, 5, 1'b1);
        start(1, 5, 5);
        wait_done(100);
        check("t4_nwr", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            py = i / 2;
            px = i % 2;
            if (i < wr_log.size()) begin
                check("t4_wr_addr", 32'(wr_log[i].addr), 196608 + py * 32 + px);
                check("t4_wr_data", wr_log[i].data, 32'((2 * px + 1) * 10 - 6 * py));
            end
        end
        check("t4_nrd", rd_log.size(), 16);
        nbad = 0;
        foreach (rd_log[i]) begin
            off = rd_log[i].addr - 18'd131072;
            if (off[9:5] == 5'd4 || off[4:0] == 5'd4) nbad++;
        end
        check("t4_edge_reads", nbad, 0);

        // Degenerate sizes go straight to DONE
        start(0, 4, 4);
        wait_done(20);
        check("t5a_nrd", rd_log.size(), 0);
        check("t5a_nwr", wr_log.size(), 0);
        check("t5a_done_t", done_t, 1);
        check("t5a_busy_cnt", busy_cnt, 1);
        start(1, 4, 1);
        wait_done(20);
        check("t5b_nrd", rd_log.size(), 0);
        check("t5b_nwr", wr_log.size(), 0);
        check("t5b_done_t", done_t, 1);
        check("t5b_busy_cnt", busy_cnt, 1);

        // Busy-time enable ignored; reset during DRAIN of window 2 aborts
        load_pattern(2, 4, 1'b0);
        start(2, 4, 4);
        repeat (2) @(negedge clk);
        num_chnl = 5'd1;
        ofmap_height = 6'd2;
        ofmap_width = 6'd2;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int n = 0; n < 40 && (cyc - t0 + 1) < 17; n++) @(negedge clk);
        check("t6_at_T17", cyc - t0 + 1, 17);
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_nwr_pre", wr_log.size(), 2);
        if (wr_log.size() > 1) check("t6_wr1_addr", 32'(wr_log[1].addr), 196609);
        srstn = 1'b0;
        #1;
        check_outputs_zero("t6_abort");
        @(negedge clk);
        srstn = 1'b1;
        clear_logs();
        repeat (12) @(negedge clk);
        check("t6_nwr_idle", wr_log.size(), 0);
        check("t6_nrd_idle", rd_log.size(), 0);
        check("t6_busy_idle", busy_cnt, 0);

        load_small(5, -3, 7, 1);
        start(1, 2, 2);
        wait_done(50);
        check("t6_re_nwr", wr_log.size(), 1);
        if (wr_log.size() > 0) begin
            check("t6_re_wr_addr", 32'(wr_log[0].addr), 196608);
            check("t6_re_wr_data", wr_log[0].data, 7);
        end
        if (rd_log.size() > 0) check("t6_re_rd0", 32'(rd_log[0].addr), 131072);
        check("t6_re_done_t", done_t, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
